tdc_uart_rx: RTL

Serial receiver for the TDC measurement link. It deserializes the 8N1 UART stream driven by the TDC core's `tx` output and reassembles consecutive bytes into one measurement word. Each complete word is presented with a one-cycle valid strobe. It sits on the capture/host side of the link, or in loopback on the same die for self-test, and uses the same clock as the transmitter.

---
 rtl/tdc_uart_rx.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/tdc_uart_rx.sv
// 8N1 UART receiver for the TDC measurement link; assembles BYTES_PER_WORD bytes
// (first byte most significant) into one word with an inter-byte timeout.
module tdc_uart_rx #(
    parameter int CLKS_PER_BIT   = 104,
    parameter int BYTES_PER_WORD = 2,
    parameter int TIMEOUT_BITS   = 20
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rx,
    output logic [8*BYTES_PER_WORD-1:0] data,
    output logic                        valid,
    output logic                        frame_err,
    output logic                        word_drop,
    output logic                        busy
);
    // state  | meaning
    // IDLE   | line idle, waiting for a 1->0 edge on rxs
    // START  | half-bit wait, confirm start bit is still low
    // DATA   | sample 8 data bits LSB first, one per bit period
    // STOP   | sample stop bit; good byte or framing error
    // BREAK  | line held low after framing error, wait for it to go high
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    localparam int W    = 8 * BYTES_PER_WORD;
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int GAP  = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int GW   = $clog2(GAP + 1);
    localparam int BCW  = $clog2(BYTES_PER_WORD + 1);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     shift_q, shift_d;
    logic           rx_meta, rxs, rxs_d;
    logic [1:0]     settle;
    logic           start_det, byte_ok, byte_bad;
    logic [W-1:0]   acc_q;
    logic [W-1:0]   acc_next;
    logic [BCW-1:0] byte_cnt;
    logic [GW-1:0]  gap_q;

    assign busy     = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    assign acc_next = (acc_q << 8) | W'(shift_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        start_det = 1'b0;
        byte_ok   = 1'b0;
        byte_bad  = 1'b0;
        if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
        case (state_q)
            IDLE: begin
                // settle blocks the synchronizer's reset value from faking an edge
                if (settle == 2'd3 && rxs_d && !rxs) begin
                    state_d   = START;
                    cnt_d     = CW'(HALF - 1);
                    start_det = 1'b1;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (!rxs) begin
                        state_d = DATA;
                        cnt_d   = CW'(CLKS_PER_BIT - 1);
                        idx_d   = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rxs, shift_q[7:1]};
                    cnt_d   = CW'(CLKS_PER_BIT - 1);
                    if (idx_q == 3'd7)
                        state_d = STOP;
                    else
                        idx_d = idx_q + 3'd1;
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    if (rxs) begin
                        state_d = IDLE;
                        byte_ok = 1'b1;
                    end else begin
                        state_d  = BREAK;
                        byte_bad = 1'b1;
                    end
                end
            end
            BREAK: begin
                if (rxs)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta   <= 1'b1;
            rxs       <= 1'b1;
            rxs_d     <= 1'b1;
            settle    <= 2'd0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            shift_q   <= 8'd0;
            acc_q     <= '0;
            byte_cnt  <= '0;
            gap_q     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            word_drop <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rxs       <= rx_meta;
            rxs_d     <= rxs;
            if (settle != 2'd3)
                settle <= settle + 2'd1;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            word_drop <= 1'b0;

            if (byte_ok) begin
                if (byte_cnt == BCW'(BYTES_PER_WORD - 1)) begin
                    data     <= acc_next;
                    valid    <= 1'b1;
                    byte_cnt <= '0;
                    acc_q    <= '0;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                    acc_q    <= acc_next;
                end
            end else if (byte_bad) begin
                byte_cnt  <= '0;
                acc_q     <= '0;
                frame_err <= 1'b1;
            end

            // gap timer only runs in IDLE with a partial word pending
            if (state_q != IDLE || start_det) begin
                gap_q <= GW'(GAP - 1);
            end else if (byte_cnt != '0) begin
                if (gap_q == '0) begin
                    byte_cnt  <= '0;
                    acc_q     <= '0;
                    word_drop <= 1'b1;
                    gap_q     <= GW'(GAP - 1);
                end else begin
                    gap_q <= gap_q - 1'b1;
                end
            end
        end
    end
endmodule
